// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: steps a 1-bit add/sub cell LSB-first,
// one bit per clock, and reports result, unsigned carry-out and signed overflow.

module addsub_cell (
    input  logic a,
    input  logic b,
    input  logic ctl,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic bb;

    always_comb begin
        bb   = b ^ ctl;
        s    = a ^ bb ^ cin;
        cout = (a & bb) | (a & cin) | (bb & cin);
    end
endmodule

module serial_addsub_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_lat, b_lat;
    logic             op_lat;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             sum_bit, carry_next;

    addsub_cell u_cell (
        .a    (a_lat[cnt]),
        .b    (b_lat[cnt]),
        .ctl  (op_lat),
        .cin  (carry),
        .s    (sum_bit),
        .cout (carry_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_lat    <= '0;
            b_lat    <= '0;
            op_lat   <= 1'b0;
            cnt      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1: the +1 rides in on the carry.
                        a_lat  <= a;
                        b_lat  <= b;
                        op_lat <= op;
                        cnt    <= '0;
                        carry  <= op;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    result <= {sum_bit, result[WIDTH-1:1]};
                    carry  <= carry_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        // carry still holds the carry into the MSB here
                        cout     <= carry_next;
                        overflow <= carry ^ carry_next;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.

module tb_serial_addsub_ctrl;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             op = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, cout, overflow;
    logic [WIDTH-1:0] result;

    int   total = 0;
    int   bad = 0;
    int   accepts = 0;
    int   dones = 0;
    exp_t sb[$];

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic sub);
        logic [WIDTH:0] full;
        exp_t e;
        if (sub) full = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        else     full = {1'b0, x} + {1'b0, y};
        e.r = full[WIDTH-1:0];
        e.c = full[WIDTH];
        if (sub) e.v = (x[WIDTH-1] != y[WIDTH-1]) && (e.r[WIDTH-1] != x[WIDTH-1]);
        else     e.v = (x[WIDTH-1] == y[WIDTH-1]) && (e.r[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            dones++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got=%0h want=no_done at %0t", result, $time);
            end else begin
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.r));
                check("cout", 32'(cout), 32'(e.c));
                check("overflow", 32'(overflow), 32'(e.v));
            end
        end
    end

    // Called #1 after the accept edge; checks exact latency and the busy tail.
    task automatic finish_op();
        int n = 0;
        check("busy_after_accept", 32'(busy), 32'd1);
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 40);
        check("done_latency", 32'(n), 32'(WIDTH));
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_drop", 32'(busy), 32'd0);
    endtask

    // Entered #1 after a posedge with the DUT idle.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic sub, input exp_t e);
        a = x; b = y; op = sub; start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        accepts++;
        start = 1'b0;
        finish_op();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, expectations computed by hand.
        run_op(8'h3C, 8'h15, 1'b0, '{r: 8'h51, c: 1'b0, v: 1'b0});
        run_op(8'h15, 8'h3C, 1'b1, '{r: 8'hD9, c: 1'b0, v: 1'b0});
        run_op(8'h80, 8'h01, 1'b1, '{r: 8'h7F, c: 1'b1, v: 1'b1});
        run_op(8'h7F, 8'h01, 1'b0, '{r: 8'h80, c: 1'b0, v: 1'b1});
        run_op(8'hFF, 8'h01, 1'b0, '{r: 8'h00, c: 1'b1, v: 1'b0});
        run_op(8'h00, 8'h00, 1'b1, '{r: 8'h00, c: 1'b1, v: 1'b0});
        run_op(8'hFF, 8'hFF, 1'b0, '{r: 8'hFE, c: 1'b1, v: 1'b0});
        check("idle_result_stable", 32'(result), 32'hFE);

        // start held through RUN with new operands: first op keeps latched values,
        // second is taken only in the IDLE cycle after DONE.
        a = 8'h3C; b = 8'h15; op = 1'b0; start = 1'b1;
        sb.push_back('{r: 8'h51, c: 1'b0, v: 1'b0});
        @(posedge clk); #1;
        accepts++;
        a = 8'hAA; b = 8'h55; op = 1'b1;
        sb.push_back('{r: 8'h55, c: 1'b1, v: 1'b1});
        repeat (WIDTH) @(posedge clk);
        #1;
        check("held_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("no_accept_in_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        accepts++;
        start = 1'b0;
        finish_op();

        // Asynchronous reset after 3 bits: outputs clear at once, no done.
        a = 8'h3C; b = 8'h15; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        #2;
        rst_n = 1'b1;
        repeat (WIDTH + 3) @(posedge clk);
        #1;
        check("abort_still_idle", 32'(busy), 32'd0);
        run_op(8'h01, 8'h02, 1'b0, '{r: 8'h03, c: 1'b0, v: 1'b0});

        // Random regression against the behavioural model.
        for (int i = 0; i < 1000; i++) begin
            logic [WIDTH-1:0] x, y;
            logic sub;
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            sub = 1'($urandom);
            if (i % 10 == 0) x = (i % 20 == 0) ? 8'h00 : 8'hFF;
            if (i % 7 == 0)  y = (i % 14 == 0) ? 8'hFF : 8'h00;
            e = model(x, y, sub);
            run_op(x, y, sub, e);
        end

        repeat (2) @(posedge clk);
        #1;
        check("done_count", 32'(dones), 32'(accepts));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
